// File: rtl/pes_bcd_updown_counter.sv
// N-digit packed-BCD up/down counter with validated parallel load, terminal count and wrap/load-error pulses.
// Define PES_BCDC_SAT_EN to make the counter saturate at its end values instead of wrapping.
module pes_bcd_updown_counter #(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  CK,
    input  logic                  RN,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  LD,
    input  logic [4*DIGITS-1:0]   D,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  TC,
    output logic                  WRAP,
    output logic                  LDERR
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] q_step;
    logic [W-1:0] q_next;
    logic [3:0]   dig;
    logic         carry_up;
    logic         carry_dn;
    logic         all9;
    logic         all0;
    logic         d_ok;
    logic         at_end;
    logic         wrap_hit;

    // Ripple the all-lower-digits-at-9 / at-0 conditions from the units digit upward.
    always_comb begin
        q_step   = Q;
        dig      = 4'd0;
        carry_up = 1'b1;
        carry_dn = 1'b1;
        d_ok     = 1'b1;
        for (int k = 0; k < int'(DIGITS); k++) begin
            dig = Q[4*k +: 4];
            if (UP) begin
                if (carry_up) q_step[4*k +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            end else begin
                if (carry_dn) q_step[4*k +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            carry_up = carry_up & (dig == 4'd9);
            carry_dn = carry_dn & (dig == 4'd0);
            d_ok     = d_ok & (D[4*k +: 4] <= 4'd9);
        end
        all9 = carry_up;
        all0 = carry_dn;
    end

    assign at_end = UP ? all9 : all0;
    assign TC     = EN & at_end;

`ifdef PES_BCDC_SAT_EN
    assign q_next   = at_end ? Q : q_step;
    assign wrap_hit = 1'b0;
`else
    assign q_next   = q_step;
    assign wrap_hit = at_end;
`endif

    // Load beats count; pulses clear every cycle unless re-caused.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            Q     <= '0;
            WRAP  <= 1'b0;
            LDERR <= 1'b0;
        end else begin
            WRAP  <= 1'b0;
            LDERR <= 1'b0;
            if (LD) begin
                if (d_ok) Q <= D;
                else      LDERR <= 1'b1;
            end else if (EN) begin
                Q    <= q_next;
                WRAP <= wrap_hit;
            end
        end
    end

endmodule

// File: doc/pes_bcd_updown_counter.md
# pes_bcd_updown_counter

Parametrised N-digit BCD up/down counter: the next generation of the team's two-digit BCD counter. It adds these features over the two-digit block:
- configurable digit count
- runtime count direction
- synchronous parallel load with BCD validity check
- terminal-count and registered wrap outputs for cascading

It sits between free-running clock-enable logic and display/decode stages that consume packed BCD digits.

## Interface
- DIGITS, default 2: number of BCD digits, legal range 1..8. Count range is 0 .. 10^DIGITS-1.
- CK  input  1  clock, rising edge active
- RN  input  1  asynchronous active-low reset
- EN  input  1  count enable, sampled on CK rising edge
- UP  input  1  direction: 1 counts up, 0 counts down
- LD  input  1  synchronous parallel load request
- D  input  4*DIGITS  load value, packed BCD, digit 0 (units) in D[3:0]
- Q  output  4*DIGITS  count value, packed BCD, units in Q[3:0]
- TC  output  1  terminal count, combinational
- WRAP  output  1  registered one-cycle pulse after the counter wraps
- LDERR  output  1  registered one-cycle pulse after a rejected load

## Operation
- Priority on each CK edge: RN low, then LD, then EN, then hold.
- LD=1:
  - If every nibble of D is 0..9, Q<=D.
  - If any nibble is A..F, Q holds and LDERR pulses.
  - LD ignores EN and UP. WRAP=0 on load cycles.
- EN=1, LD=0, UP=1: digit k increments when all lower digits are 9; otherwise it holds.
  - A digit at 9 that increments becomes 0.
  - All digits at 9 → all digits become 0, and WRAP pulses.
- EN=1, LD=0, UP=0: digit k decrements when all lower digits are 0.
  - A digit at 0 that decrements becomes 9.
  - All digits at 0 → all digits become 9, and WRAP pulses.
- Each digit is an independent 4-bit register. Nibble values A..F are never produced by counting. The load check guarantees they never enter the register.
- TC = EN & ((UP & Q==all 9s) | (~UP & Q==0)). TC is used as EN of a cascaded counter stage.
- UP may change on any cycle. The new direction takes effect on that same edge; there is no turnaround state.

## Timing
- Reset (RN low, asynchronous, at any time including mid-count): Q=0, WRAP=0, LDERR=0 immediately. TC follows Q=0, so TC=EN&~UP.
- RN deassertion is synchronised externally. The first active edge after release may count.
- Q latency: 1 cycle from sampled EN/LD to the updated Q.
- WRAP and LDERR are asserted for exactly the one cycle after the causing edge. They are not sticky.
- TC is combinational from Q, UP and EN, with no added latency. It is glitch-free relative to CK only.
- Back-to-back loads, load on the wrap boundary, and enable toggling every cycle must all be handled with no lost or double counts.

## Configuration
- PES_BCDC_SAT_EN defined: the counter saturates instead of wrapping.
  - Up at all 9s holds all 9s. Down at 0 holds 0.
  - WRAP is tied 0.
  - TC behaviour is unchanged.
- Undefined (default): wrap-around behaviour as in Operation.

## Test plan
- DIGITS=2, reset, EN=1, UP=1 for 101 cycles → Q steps 0x00..0x99 and then returns to 0x00. WRAP high exactly in the cycle after 0x99→0x00. TC high only while Q=0x99.
- DIGITS=2, Q=0x10, EN=1, UP=0 → Q sequence 0x09, 0x08 … 0x00, 0x99. WRAP pulses once, after 0x00→0x99.
- LD=1, D=0x47, EN=1 → Q=0x47 next cycle, LDERR=0. Then LD=1, D=0x4A → Q stays 0x47 and LDERR pulses for one cycle.
- DIGITS=3, load 0x199 then UP=1, EN=1 → Q=0x200. Then UP=0 on the next edge → Q=0x199. No WRAP.
- Assert RN low asynchronously mid-cycle while Q=0x57 and EN=1 → Q=0x00 and WRAP=LDERR=0 before the next CK edge. Counting resumes from 0x00 after release.
- Build with PES_BCDC_SAT_EN, DIGITS=2:
  - Q=0x99, UP=1, EN=1 for 5 cycles → Q stays 0x99, WRAP stays 0.
  - Q=0x00, UP=0 → Q stays 0x00.
